ar_multicore_agu: RTL
=====================

Name: ar_multicore_agu

Overview:
Parametrised successor to the single 16-bit address register, serving N_CORES data-memory ports at once. It holds a base address loaded from the bus and drives one address lane per core, lane i = base + i*CORE_STRIDE. It adds single-step increment, a self-timed burst mode (FSM plus down-counter) and a sticky overflow flag. It sits between the shared bus BIN and the per-core data-memory address inputs.

Parameters:
WIDTH, 16, address width in bits
N_CORES, 4, number of cores / address lanes (>=1)
CORE_STRIDE, 1, address offset between adjacent lanes
CNT_W, 8, width of burst length counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
BIN  input  WIDTH  bus data to load as base
WR  input  1  load base from BIN
INC  input  1  single step: base += STEP
BURST_START  input  1  start burst of BURST_LEN steps
BURST_LEN  input  CNT_W  number of burst steps
DMADDR  output  N_CORES*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
BUSY  output  1  burst in progress
DONE  output  1  one-cycle pulse, burst completed
OVF  output  1  sticky base-wrap flag

Behaviour:
- STEP = N_CORES*CORE_STRIDE, truncated to WIDTH. All address arithmetic is modulo 2^WIDTH.
- Lane i output = base + i*CORE_STRIDE mod 2^WIDTH. Lanes update on the same edge as base, so there is no extra latency (registered per lane or derived from the base register).
- Reset (rst=1 at edge): base=0, so DMADDR lane i = i*CORE_STRIDE. Also BUSY=0, DONE=0, OVF=0, state=IDLE, count=0. rst overrides every other input, including mid-burst.
- Priority per edge: rst > WR > burst step (state RUN) > BURST_START (state IDLE) > INC (state IDLE).
- WR: base<=BIN; OVF<=0; any burst is aborted: state<=IDLE, count<=0, no DONE pulse.
- INC in IDLE: base<=base+STEP. INC is ignored in RUN and DONE.
- OVF: set when a base update (INC or burst step) carries out of WIDTH. Stays set until WR or rst. Wrap in lanes i>0 alone does not set OVF.
- FSM states:
  - IDLE: BUSY=0, DONE=0.
  - On BURST_START with LEN>0: count<=LEN, state<=RUN, base unchanged on that edge.
  - On BURST_START with LEN=0: state<=DONE, no step.
  - RUN: BUSY=1. Each edge: base+=STEP, count-=1. When count goes 1->0: state<=DONE. BURST_START is ignored in RUN.
  - DONE: DONE=1, BUSY=0, lasts one cycle, then IDLE. BURST_START and INC are ignored in DONE.
- Timing: BURST_START sampled at edge k gives steps at edges k+1..k+LEN, BUSY high for exactly LEN cycles, DONE high during the cycle after edge k+LEN.
- Simultaneous WR+INC or WR+BURST_START: WR wins and the other is dropped.
- BUSY, DONE and OVF are registered outputs. There are no combinational input-to-output paths except lane derivation from base.

Decomposition:
- Shared package/header (ar_pkg):
  - FSM state encoding localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default WIDTH/CNT_W constants.
  - STEP computation function.
- One natural sub-module, ar_burst_fsm:
  - Contents: state register plus down-counter.
  - Inputs: rst, WR (abort), BURST_START, BURST_LEN.
  - Outputs: step_en, BUSY, DONE.
  - The top level holds base, lane derivation and OVF.

Test Plan:
(All with WIDTH=16, N_CORES=4, CORE_STRIDE=1, so STEP=4.)
1. Reset: assert rst 2 cycles -> DMADDR lanes 0x0000/0x0001/0x0002/0x0003; BUSY=0, DONE=0, OVF=0.
2. Load and step:
   - WR, BIN=0x0100 -> next cycle lanes 0x0100/0x0101/0x0102/0x0103.
   - INC -> lanes 0x0104..0x0107.
   - INC+WR same cycle with BIN=0x0200 -> lane0=0x0200.
3. Burst: from base 0x0100, BURST_START with LEN=3:
   - BUSY high 3 cycles; lane0 goes 0x0104, 0x0108, 0x010C.
   - DONE high exactly 1 cycle after, then IDLE.
   - INC asserted during BUSY has no effect.
4. Zero-length burst: LEN=0 -> DONE pulses next cycle, BUSY never asserts, base unchanged.
5. Wrap: WR BIN=0xFFFE, then INC -> lanes 0x0002/0x0003/0x0004/0x0005, OVF=1. OVF holds through further INC. WR 0x0000 clears OVF.
6. Abort:
   - Burst LEN=10 from 0x0000; WR BIN=0x0040 on 3rd BUSY cycle -> next cycle BUSY=0, lane0=0x0040, no DONE pulse.
   - Repeat with rst instead of WR -> full reset values.

Source files
------------

// File: rtl/ar_multicore_agu_pkg.sv
// Shared definitions for the multicore address generator: burst FSM states,
// default widths and the per-step base increment.
package ar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_CNT_W = 8;

  // Base advances past every lane in one step so consecutive steps never overlap.
  function automatic int unsigned calc_step(input int unsigned n_cores,
                                            input int unsigned core_stride);
    return n_cores * core_stride;
  endfunction

endpackage

// File: rtl/ar_multicore_agu_burst_fsm.sv
// Self-timed burst sequencer: IDLE -> RUN (LEN cycles of step_en) -> DONE -> IDLE.
// BUSY/DONE are registered; WR aborts to IDLE with no DONE pulse.
module ar_burst_fsm
  import ar_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
  output logic             step_en,
  output logic             idle,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    if (wr) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (burst_start) begin
            if (burst_len != '0) begin
              count_d = burst_len;
              state_d = ST_RUN;
              busy_d  = 1'b1;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
        ST_RUN: begin
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            busy_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign step_en = (state_q == ST_RUN);
  assign idle    = (state_q == ST_IDLE);
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: rtl/ar_multicore_agu.sv
// Base address register fanned out to N_CORES lanes (lane i = base + i*CORE_STRIDE),
// with single-step INC, self-timed bursts and a sticky carry-out flag; lanes follow base with zero latency.
module ar_multicore_agu
  import ar_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned N_CORES     = 4,
  parameter int unsigned CORE_STRIDE = 1,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         BIN,
  input  logic                     WR,
  input  logic                     INC,
  input  logic                     BURST_START,
  input  logic [CNT_W-1:0]         BURST_LEN,
  output logic [N_CORES*WIDTH-1:0] DMADDR,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     OVF
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(calc_step(N_CORES, CORE_STRIDE));

  logic [WIDTH-1:0] base_q, base_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   sum;
  logic             step_en, idle, inc_en;

  ar_burst_fsm #(.CNT_W(CNT_W)) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .wr          (WR),
    .burst_start (BURST_START),
    .burst_len   (BURST_LEN),
    .step_en     (step_en),
    .idle        (idle),
    .busy        (BUSY),
    .done        (DONE)
  );

  // A burst start in IDLE takes the edge, so a coincident INC is dropped.
  assign inc_en = INC && idle && !BURST_START;

  always_comb begin
    sum    = {1'b0, base_q} + {1'b0, STEP};
    base_d = base_q;
    ovf_d  = ovf_q;
    if (WR) begin
      base_d = BIN;
      ovf_d  = 1'b0;
    end else if (step_en || inc_en) begin
      base_d = sum[WIDTH-1:0];
      if (sum[WIDTH]) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      base_q <= base_d;
      ovf_q  <= ovf_d;
    end
  end

  for (genvar i = 0; i < N_CORES; i++) begin : g_lane
    assign DMADDR[i*WIDTH +: WIDTH] = base_q + WIDTH'(i * CORE_STRIDE);
  end

  assign OVF = ovf_q;

endmodule
